// File: rtl/cnn_pkg.sv
// Shared CNN pipeline definitions: FSM state encodings, frame-geometry
// helpers and a signed maximum used by the pooling layers.
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        ACC  = 3'b100,
        EMIT = 3'b101,
        DROP = 3'b110
    } state_e;

    // Widest channel word the signed-max helper can handle.
    localparam int unsigned MAX_DW = 64;

    // Number of complete pooling windows in a frame.
    function automatic int unsigned out_seq_of(input int unsigned in_seq,
                                               input int unsigned pool);
        return in_seq / pool;
    endfunction

    // Trailing samples that do not fill a whole window.
    function automatic int unsigned rem_of(input int unsigned in_seq,
                                           input int unsigned pool);
        return in_seq % pool;
    endfunction

    // Bits needed for a counter running 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Signed maximum on sign-extended operands; callers extend and truncate.
    function automatic logic signed [MAX_DW-1:0] smax(
        input logic signed [MAX_DW-1:0] a,
        input logic signed [MAX_DW-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool_lane.sv
// One pooling channel: running signed maximum with load/compare enables and
// an optional ReLU clamp on the value presented to the output register.
module maxpool_lane
    import cnn_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter bit          RELU = 1'b1
) (
    input  logic          clk,
    input  logic          RSTn,
    input  logic          i_load,
    input  logic          i_cmp,
    input  logic [DW-1:0] i_word,
    output logic [DW-1:0] o_pooled
);

    logic [DW-1:0] max_q;
    logic [DW-1:0] max_d;

    // Next running maximum: first word of a window loads, later words compete.
    always_comb begin
        max_d = max_q;
        if (i_load) begin
            max_d = i_word;
        end else if (i_cmp) begin
            max_d = DW'(smax(MAX_DW'(signed'(max_q)), MAX_DW'(signed'(i_word))));
        end
    end

    // Running-maximum register.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    // ReLU clamp on negative results when enabled.
    always_comb begin
        o_pooled = max_q;
        if (RELU && max_q[DW-1]) begin
            o_pooled = '0;
        end
    end

endmodule

// File: rtl/maxpool1d.sv
// Channel-parallel 1D max-pooling stage with optional ReLU. Accumulates POOL
// samples per window across IN_CH lanes and emits one pooled sample per
// window over a stb/ack handshake; trailing samples of a frame are dropped.
module maxpool1d
    import cnn_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter int unsigned IN_CH  = 4,
    parameter int unsigned IN_SEQ = 46,
    parameter int unsigned POOL   = 2,
    parameter int unsigned RELU   = 1
) (
    input  logic                clk,
    input  logic                RSTn,
    input  logic                i_EN,
    output logic                o_busy,
    input  logic [DW*IN_CH-1:0] i_data,
    input  logic                i_stb_in,
    output logic                o_ack_in,
    output logic [DW*IN_CH-1:0] o_data,
    output logic                o_stb_out,
    input  logic                i_ack_out
);

    localparam int unsigned OUT_SEQ = out_seq_of(IN_SEQ, POOL);
    localparam int unsigned REM     = rem_of(IN_SEQ, POOL);
    localparam int unsigned WCW     = cnt_width(POOL);
    localparam int unsigned OCW     = cnt_width(OUT_SEQ + 1);

    localparam logic [WCW-1:0] WIN_LAST  = WCW'(POOL - 1);
    localparam logic [WCW-1:0] DROP_LAST = WCW'((REM == 0) ? 0 : REM - 1);
    localparam logic [OCW-1:0] OUT_LAST  = OCW'(OUT_SEQ - 1);

    state_e               state_q,   state_d;
    logic [WCW-1:0]       win_cnt_q, win_cnt_d;
    logic [OCW-1:0]       out_cnt_q, out_cnt_d;
    logic                 ack_q,     ack_d;
    logic                 stb_q,     stb_d;
    logic [DW*IN_CH-1:0]  data_q,    data_d;

    logic                 in_xfer;
    logic                 lane_load;
    logic                 lane_cmp;
    logic [DW*IN_CH-1:0]  pooled;

    assign in_xfer   = i_stb_in && ack_q;
    assign o_busy    = (state_q != IDLE);
    assign o_ack_in  = ack_q;
    assign o_stb_out = stb_q;
    assign o_data    = data_q;

    for (genvar g = 0; g < IN_CH; g++) begin : g_lane
        maxpool_lane #(
            .DW   (DW),
            .RELU (RELU != 0)
        ) u_lane (
            .clk      (clk),
            .RSTn     (RSTn),
            .i_load   (lane_load),
            .i_cmp    (lane_cmp),
            .i_word   (i_data[g*DW +: DW]),
            .o_pooled (pooled[g*DW +: DW])
        );
    end

    // State, counter and handshake registers.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= IDLE;
            win_cnt_q <= '0;
            out_cnt_q <= '0;
            ack_q     <= 1'b0;
            stb_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            out_cnt_q <= out_cnt_d;
            ack_q     <= ack_d;
            stb_q     <= stb_d;
            data_q    <= data_d;
        end
    end

    // Next-state logic: frame start, window completion, emit and drop phases.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (i_EN) state_d = ACC;
            ACC:  if (in_xfer && (win_cnt_q == WIN_LAST)) state_d = EMIT;
            EMIT: begin
                if (!stb_q) begin
                    if (out_cnt_q == OUT_LAST) begin
                        state_d = (REM > 0) ? DROP : IDLE;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            DROP: if (in_xfer && (win_cnt_q == DROP_LAST)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath controls: counters, lane enables, input ack and output register.
    always_comb begin
        win_cnt_d = win_cnt_q;
        out_cnt_d = out_cnt_q;
        ack_d     = 1'b0;
        stb_d     = stb_q;
        data_d    = data_q;
        lane_load = 1'b0;
        lane_cmp  = 1'b0;
        case (state_q)
            IDLE: begin
                win_cnt_d = '0;
                out_cnt_d = '0;
            end
            ACC: begin
                ack_d = !in_xfer;
                if (in_xfer) begin
                    lane_load = (win_cnt_q == '0);
                    lane_cmp  = (win_cnt_q != '0);
                    win_cnt_d = (win_cnt_q == WIN_LAST) ? '0 : win_cnt_q + 1'b1;
                end
            end
            EMIT: begin
                if (!stb_q) begin
                    data_d    = pooled;
                    stb_d     = 1'b1;
                    out_cnt_d = out_cnt_q + 1'b1;
                end
            end
            DROP: begin
                ack_d = !in_xfer;
                if (in_xfer) begin
                    win_cnt_d = (win_cnt_q == DROP_LAST) ? '0 : win_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        // Output ack is applied last; a load only happens with stb_q low, so
        // it never collides with this clear.
        if (stb_q && i_ack_out) begin
            stb_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_maxpool1d.sv
// Self-checking bench for maxpool1d: table-driven frames on several
// parameterisations plus hand-written backpressure, reset and full-frame runs.
module tb_maxpool1d;

    localparam int DW    = 32;
    localparam int CH    = 4;
    localparam int W     = DW * CH;
    localparam int N_DUT = 5;

    localparam int SEQ_P  [N_DUT] = '{4, 4, 5, 46, 7};
    localparam int POOL_P [N_DUT] = '{2, 2, 2, 2, 3};
    localparam int RELU_P [N_DUT] = '{1, 0, 1, 1, 0};

    logic         clk = 1'b0;
    logic         rstn    [N_DUT];
    logic         en      [N_DUT];
    logic [W-1:0] din     [N_DUT];
    logic         stb_i   [N_DUT];
    logic         ack_o   [N_DUT];
    logic [W-1:0] dout    [N_DUT];
    logic         stb_o   [N_DUT];
    logic         ack_out [N_DUT];
    logic         busy    [N_DUT];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        maxpool1d #(
            .DW     (DW),
            .IN_CH  (CH),
            .IN_SEQ (SEQ_P[g]),
            .POOL   (POOL_P[g]),
            .RELU   (RELU_P[g])
        ) u_dut (
            .clk       (clk),
            .RSTn      (rstn[g]),
            .i_EN      (en[g]),
            .o_busy    (busy[g]),
            .i_data    (din[g]),
            .i_stb_in  (stb_i[g]),
            .o_ack_in  (ack_o[g]),
            .o_data    (dout[g]),
            .o_stb_out (stb_o[g]),
            .i_ack_out (ack_out[g])
        );
    end

    typedef struct {
        int          dut;
        int          n_in;
        logic [31:0] c0 [8];
        logic [31:0] c1 [8];
        int          n_out;
        logic [31:0] e0 [4];
        logic [31:0] e1 [4];
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Lanes 2/3 mirror lanes 0/1.
    function automatic logic [W-1:0] pk(input logic [31:0] a, input logic [31:0] b);
        return {b, a, b, a};
    endfunction

    function automatic logic [W-1:0] pool_ref(input logic [W-1:0] s[$], input int base,
                                              input int pool, input int relu);
        logic [W-1:0]       r;
        logic signed [31:0] m;
        logic signed [31:0] v;
        r = '0;
        for (int l = 0; l < CH; l++) begin
            m = s[base][l*32 +: 32];
            for (int j = 1; j < pool; j++) begin
                v = s[base+j][l*32 +: 32];
                if (v > m) m = v;
            end
            if (relu != 0 && m < 0) m = 0;
            r[l*32 +: 32] = m;
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input int k, input logic [W-1:0] d, output bit ok);
        int t = 0;
        stb_i[k] = 1'b1;
        din[k]   = d;
        while (!ack_o[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        stb_i[k] = 1'b0;
        ok = (t < 200);
    endtask

    task automatic run_frame(input int k, input logic [W-1:0] smp[$], input logic [W-1:0] exp[$],
                             input bit rnd, input string tag);
        logic [W-1:0] got[$];
        bit pdone = 1'b0;
        bit tmo   = 1'b0;
        en[k] = 1'b1;
        @(negedge clk);
        en[k] = 1'b0;
        fork
            begin
                bit ok;
                foreach (smp[i]) begin
                    if (rnd) repeat ($urandom_range(0, 3)) @(negedge clk);
                    send(k, smp[i], ok);
                    if (!ok) tmo = 1'b1;
                end
                pdone = 1'b1;
            end
            begin
                int idle = 0;
                int cyc  = 0;
                while (idle < 12 && cyc < 2000) begin
                    ack_out[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (stb_o[k] && ack_out[k]) got.push_back(dout[k]);
                    if (pdone && !stb_o[k]) idle++;
                    else idle = 0;
                    @(negedge clk);
                    cyc++;
                end
                if (cyc >= 2000) tmo = 1'b1;
            end
        join
        ack_out[k] = 1'b1;
        check({tag, " timeout"}, W'(tmo), '0);
        check({tag, " count"}, W'(got.size()), W'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            check($sformatf("%s out%0d", tag, i), (i < got.size()) ? got[i] : 'x, exp[i]);
        end
        check({tag, " busy_end"}, W'(busy[k]), '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] smp[$];
        logic [W-1:0] exp[$];
        logic [W-1:0] held;
        logic [W-1:0] got[$];
        bit pdone;
        int hold_bad;
        int t;

        for (int i = 0; i < N_DUT; i++) begin
            rstn[i] = 1'b0; en[i] = 1'b0; din[i] = '0; stb_i[i] = 1'b0; ack_out[i] = 1'b0;
        end
        #2;
        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("reset data d%0d", i), dout[i], '0);
            check($sformatf("reset ctl d%0d", i), W'({busy[i], ack_o[i], stb_o[i]}), '0);
        end
        @(negedge clk);
        for (int i = 0; i < N_DUT; i++) rstn[i] = 1'b1;
        @(negedge clk);

        // dut, n_in, ch0 in, ch1 in, n_out, ch0 expected, ch1 expected
        vecs[0].dut = 0; vecs[0].n_in = 4; vecs[0].n_out = 2;
        vecs[0].c0 = '{5, -3, 7, 9, 0, 0, 0, 0};
        vecs[0].c1 = '{1, 2, 3, 4, 0, 0, 0, 0};
        vecs[0].e0 = '{5, 9, 0, 0};
        vecs[0].e1 = '{2, 4, 0, 0};
        vecs[1].dut = 0; vecs[1].n_in = 4; vecs[1].n_out = 2;
        vecs[1].c0 = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0};
        vecs[1].c1 = '{-8, -2, -5, 6, 0, 0, 0, 0};
        vecs[1].e0 = '{32'h7FFF_FFFF, 0, 0, 0};
        vecs[1].e1 = '{0, 6, 0, 0};
        vecs[2].dut = 1; vecs[2].n_in = 4; vecs[2].n_out = 2;
        vecs[2].c0 = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0};
        vecs[2].c1 = '{-8, -2, -5, 6, 0, 0, 0, 0};
        vecs[2].e0 = '{32'h7FFF_FFFF, 32'h8000_0000, 0, 0};
        vecs[2].e1 = '{32'hFFFF_FFFE, 6, 0, 0};
        vecs[3].dut = 2; vecs[3].n_in = 5; vecs[3].n_out = 2;
        vecs[3].c0 = '{1, 2, 3, 4, 100, 0, 0, 0};
        vecs[3].c1 = '{-1, -1, -7, -9, 5, 0, 0, 0};
        vecs[3].e0 = '{2, 4, 0, 0};
        vecs[3].e1 = '{0, 0, 0, 0};
        vecs[4].dut = 1; vecs[4].n_in = 4; vecs[4].n_out = 2;
        vecs[4].c0 = '{-10, -20, -30, -40, 0, 0, 0, 0};
        vecs[4].c1 = '{3, 3, -1, 0, 0, 0, 0, 0};
        vecs[4].e0 = '{-10, -30, 0, 0};
        vecs[4].e1 = '{3, 0, 0, 0};
        vecs[5].dut = 4; vecs[5].n_in = 7; vecs[5].n_out = 2;
        vecs[5].c0 = '{1, 5, 2, -4, -9, -6, 77, 0};
        vecs[5].c1 = '{0, 0, 0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1, 0};
        vecs[5].e0 = '{5, -4, 0, 0};
        vecs[5].e1 = '{0, 32'h8000_0000, 0, 0};

        for (int v = 0; v < NV; v++) begin
            smp.delete();
            exp.delete();
            for (int i = 0; i < vecs[v].n_in; i++) smp.push_back(pk(vecs[v].c0[i], vecs[v].c1[i]));
            for (int i = 0; i < vecs[v].n_out; i++) exp.push_back(pk(vecs[v].e0[i], vecs[v].e1[i]));
            run_frame(vecs[v].dut, smp, exp, 1'b0, $sformatf("v%0d", v));
        end

        // Backpressure on dut0: hold the first output for 10 cycles.
        smp.delete();
        smp.push_back(pk(5, 1)); smp.push_back(pk(-3, 2));
        smp.push_back(pk(7, 3)); smp.push_back(pk(9, 4));
        pdone = 1'b0;
        hold_bad = 0;
        held = '0;
        ack_out[0] = 1'b0;
        en[0] = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        fork
            begin
                bit ok;
                foreach (smp[i]) begin
                    send(0, smp[i], ok);
                    if (!ok) hold_bad++;
                end
                pdone = 1'b1;
            end
            begin
                t = 0;
                while (!stb_o[0] && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 100) hold_bad++;
                held = dout[0];
                repeat (10) begin
                    @(negedge clk);
                    if (!stb_o[0] || dout[0] !== held) hold_bad++;
                end
            end
        join
        check("bp stable", W'(hold_bad), '0);
        check("bp held data", held, pk(5, 2));
        check("bp all inputs taken", W'(pdone), W'(1));
        check("bp ack_in blocked", W'(ack_o[0]), '0);
        check("bp busy", W'(busy[0]), W'(1));
        got.delete();
        t = 0;
        while (t < 20) begin
            ack_out[0] = 1'b1;
            if (stb_o[0]) got.push_back(dout[0]);
            @(negedge clk);
            t++;
        end
        check("bp count", W'(got.size()), W'(2));
        check("bp out0", (got.size() > 0) ? got[0] : 'x, pk(5, 2));
        check("bp out1", (got.size() > 1) ? got[1] : 'x, pk(9, 4));
        check("bp busy_end", W'(busy[0]), '0);

        // Reset mid-window on dut1, then a fresh frame.
        en[1] = 1'b1;
        @(negedge clk);
        en[1] = 1'b0;
        begin
            bit ok;
            send(1, pk(1000, 1000), ok);
            check("rst pre send", W'(ok), W'(1));
        end
        rstn[1] = 1'b0;
        #1;
        check("rst data", dout[1], '0);
        check("rst ctl", W'({busy[1], ack_o[1], stb_o[1]}), '0);
        @(negedge clk);
        rstn[1] = 1'b1;
        @(negedge clk);
        smp.delete();
        exp.delete();
        smp.push_back(pk(-10, 3)); smp.push_back(pk(-20, 3));
        smp.push_back(pk(-30, -1)); smp.push_back(pk(-40, 0));
        exp.push_back(pk(-10, 3)); exp.push_back(pk(-30, 0));
        run_frame(1, smp, exp, 1'b0, "rst fresh");

        // Full-size frames on dut3 with random data and handshake gaps.
        for (int f = 0; f < 2; f++) begin
            smp.delete();
            exp.delete();
            for (int i = 0; i < SEQ_P[3]; i++) begin
                logic [W-1:0] s;
                s = {$urandom, $urandom, $urandom, $urandom};
                if (i % 7 == 0) s[31:0] = 32'h8000_0000;
                smp.push_back(s);
            end
            for (int w = 0; w < SEQ_P[3] / POOL_P[3]; w++) begin
                exp.push_back(pool_ref(smp, w * POOL_P[3], POOL_P[3], RELU_P[3]));
            end
            run_frame(3, smp, exp, 1'b1, $sformatf("full%0d", f));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/maxpool1d.md
Name: maxpool1d

Overview:
- Channel-parallel 1D max-pooling stage with optional ReLU. It sits directly upstream of the fully-connected stage (fc) and turns each conv-layer output frame of IN_SEQ samples into OUT_SEQ = IN_SEQ/POOL pooled samples.
- Each sample carries IN_CH channels of DW bits.
- It uses the same stb/ack handshake on both sides, so it chains conv → maxpool1d → fc with no glue.

Parameters:
- DW, 32: width of one channel word, signed two's complement.
- IN_CH, 4: channels per sample. Lanes are packed with channel i at bits [i*DW +: DW].
- IN_SEQ, 46: input samples per frame.
- POOL, 2: window length, equal to the stride. Range 1..16.
- RELU, 1: 1 clamps negative pooled results to 0; 0 passes them through.
- Derived: OUT_SEQ = IN_SEQ/POOL (floor); REM = IN_SEQ mod POOL.

Ports:
- clk, input, 1: clock, rising edge.
- RSTn, input, 1: asynchronous active-low reset.
- i_EN, input, 1: frame start, sampled in IDLE only.
- o_busy, output, 1: high whenever state != IDLE.
- i_data, input, DW*IN_CH: upstream sample.
- i_stb_in, input, 1: upstream data valid. Held by the producer until transfer.
- o_ack_in, output, 1: registered accept.
- o_data, output, DW*IN_CH: pooled sample.
- o_stb_out, output, 1: pooled sample valid.
- i_ack_out, input, 1: downstream accept.

Behaviour:
- Reset (async, RSTn=0):
  - state = IDLE; counters = 0; per-lane max registers = 0.
  - o_ack_in = 0, o_stb_out = 0, o_data = 0.
  - Reset mid-frame discards all partial results with no output.
- Input transfer:
  - A transfer happens on a clock edge where i_stb_in && o_ack_in.
  - o_ack_in is a register. In ACC/DROP it is set to 1 each cycle and forced to 0 in the cycle after a transfer, so the peak rate is 1 sample per 2 cycles.
- Output transfer:
  - A transfer happens on an edge where o_stb_out && i_ack_out; o_stb_out clears on that edge.
  - o_data is held stable while o_stb_out = 1.
  - The clear is evaluated after the FSM, so a new load and an ack in the same cycle cannot coexist; see EMIT.
- FSM:
  - IDLE:
    - o_ack_in = 0; win_cnt and out_cnt are cleared.
    - If i_EN = 1, go to ACC. i_EN in any other state is ignored.
  - ACC, on each input transfer:
    - If win_cnt == 0, every lane loads the incoming word unconditionally (no compare against 0 or a stale max). Otherwise lane = max(lane, word), using a signed compare.
    - If win_cnt == POOL-1: win_cnt = 0, go to EMIT. Otherwise win_cnt++.
  - EMIT:
    - o_ack_in = 0.
    - If o_stb_out == 0:
      - o_data lanes = RELU && max<0 ? 0 : max; o_stb_out = 1; out_cnt++.
      - Next state: if out_cnt == OUT_SEQ-1 go to DROP when REM > 0, else IDLE. Otherwise go to ACC.
    - Else stay in EMIT (backpressure; no input accepted).
  - DROP:
    - Accepts and discards REM samples with the normal handshake, then goes to IDLE.
- Latency: the first o_stb_out rises 1 cycle after the edge that transfers the last sample of a window, provided the output register is free.
- End of frame: a return to IDLE while the final o_stb_out is still pending is legal. A new frame may start, but its first EMIT waits for that sample to be acked.
- POOL = 1: ACC → EMIT on every sample (pass-through plus optional ReLU).
- Arithmetic: comparison only; no width growth. Maximum of the most negative value (-2^(DW-1)) stays exact.
- o_busy = (state != IDLE), combinational from the state register.

Decomposition:
- Shared package cnn_pkg:
  - State encodings (IDLE = 3'b000, ACC = 3'b100, EMIT = 3'b101, DROP = 3'b110).
  - Localparam helpers for OUT_SEQ/REM.
  - A signed-max function reused by later pooling layers.
- One natural sub-module, maxpool_lane:
  - One channel: max register, with load/compare enable and ReLU output mux.
  - Generated IN_CH times; the top holds the FSM, counters and handshake registers.

Test Plan:
- Basic pool (DW=32, IN_CH=4, IN_SEQ=4, POOL=2, RELU=1):
  - Stimulus: ch0 inputs 5, -3, 7, 9.
  - Required: o_data ch0 = 5 then 9; exactly 2 stb pulses; o_busy falls after the 4th input transfer's EMIT.
- ReLU:
  - Stimulus: one window with ch1 = -8, -2.
  - Required: RELU=1 outputs ch1 = 0; RELU=0 outputs ch1 = -2 (0xFFFFFFFE).
- Backpressure:
  - Stimulus: hold i_ack_out = 0 for 10 cycles after the first output.
  - Required: o_data is stable, o_ack_in stays 0 in EMIT, no input is lost; after the ack, the remaining outputs match the golden model.
- Remainder (IN_SEQ=5, POOL=2):
  - Stimulus: 5 samples.
  - Required: 2 outputs; the 5th sample is acked and dropped; the FSM returns to IDLE.
- Reset mid-frame:
  - Stimulus: assert RSTn = 0 after 1 of 2 window samples, then run a fresh frame.
  - Required: all outputs are 0 immediately; the fresh frame's results are unaffected by pre-reset data.
- Full-size frame (IN_SEQ=46, POOL=2):
  - Stimulus: random signed data, random stb/ack gaps, output fed into fc.
  - Required: 23 outputs bit-exact with the reference model; o_busy low between frames.
